// File: rtl/tkmic_pkg.sv
// Shared types and limits for the bit-serial add/subtract unit.
package tkmic_pkg;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage : tkmic_pkg

// File: rtl/tkmic_full_adder.sv
// One-bit full adder cell; the serial datapath resolves one operand bit per clock through it.
module tkmic_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : tkmic_full_adder

// File: rtl/tkmic_serial_adder.sv
// Bit-serial WIDTH-bit add/subtract unit, LSB first, with valid/ready on operand and result sides.
module tkmic_serial_adder
  import tkmic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("tkmic_serial_adder: WIDTH must lie in 2..32");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic             carry_out_q;
  logic             overflow_q;
  logic             out_valid_q;
  logic             fa_s;
  logic             fa_cout;
  logic             accept_c;
  logic             last_bit_c;

  tkmic_full_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake decode; DONE accepts new operands while the result is consumed
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    last_bit_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        last_bit_c = (bit_cnt == CNT_W'(WIDTH - 1));
        if (last_bit_c) state_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
    accept_c = in_valid && in_ready;
  end

  // Serial datapath; subtraction is A + ~B + 1 with the +1 seeded into the carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      sum_q       <= '0;
      bit_cnt     <= '0;
      carry       <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_next == DONE);
      if (accept_c) begin
        op_a    <= a;
        op_b    <= sub ? ~b : b;
        carry   <= sub;
        bit_cnt <= '0;
      end else if (state == RUN) begin
        carry   <= fa_cout;
        op_a    <= op_a >> 1;
        op_b    <= op_b >> 1;
        sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
        bit_cnt <= bit_cnt + CNT_W'(1);
        // On the MSB, carry still holds the carry into the MSB
        if (last_bit_c) begin
          carry_out_q <= fa_cout;
          overflow_q  <= carry ^ fa_cout;
        end
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule : tkmic_serial_adder

// File: tb/tb_tkmic_serial_adder.sv
// Scoreboard bench for tkmic_serial_adder at WIDTH=8 with hand-computed directed vectors.
module tb_tkmic_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry_out;
  logic       overflow;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic ov_prev = 1'b0;
  exp_t mon_e;
  int   mon_t;

  tkmic_serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: latency on each out_valid rise, scoreboard compare on each result handshake
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          mon_t = acc_q.pop_front();
          chk("latency", cyc - mon_t, 8);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sum", 32'(sum), 32'(mon_e.s));
          chk("carry_out", 32'(carry_out), 32'(mon_e.c));
          chk("overflow", 32'(overflow), 32'(mon_e.v));
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                       input logic [7:0] es, input logic ec, input logic ev, input bit keep);
    bit got;
    got = 1'b0;
    exp_q.push_back({es, ec, ev});
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      void'(exp_q.pop_back());
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev_acc;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;

    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_carry", 32'(carry_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;

    // Additions
    issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0); drain();
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); drain();
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0); drain();
    issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0); drain();
    // Subtractions, including b=0
    issue(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0); drain();
    issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0); drain();
    issue(8'hA5, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0); drain();

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    issue(8'h55, 8'h2A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("bp_valid_seen", 32'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_sum", 32'(sum), 32'h7F);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop", 32'(out_valid), 0);
    drain();

    // Back-to-back with in_valid and out_ready held high
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    prev_acc = acc_cyc;
    a = 8'hC8; b = 8'h64; sub = 1'b0;
    issue(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0, 1'b1);
    chk("b2b_spacing1", acc_cyc - prev_acc, 9);
    prev_acc = acc_cyc;
    issue(8'h50, 8'h30, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1);
    chk("b2b_spacing2", acc_cyc - prev_acc, 9);
    prev_acc = acc_cyc;
    issue(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("b2b_spacing3", acc_cyc - prev_acc, 9);
    drain();

    // Reset three cycles into RUN aborts the operation
    issue(8'h33, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_sum", 32'(sum), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_carry", 32'(carry_out), 0);
    chk("abort_ovf", 32'(overflow), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_release_in_ready", 32'(in_ready), 1);
    chk("abort_release_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0); drain();

    // Operand churn during RUN must not disturb the captured operands
    issue(8'h3C, 8'h4B, 1'b0, 8'h87, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = ~sub;
      @(posedge clk); #1;
    end
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_tkmic_serial_adder
